// File: rtl/mult_pkg.sv
// Shared definitions for the two-requester multiplier arbiter:
// FSM state encoding and requester id constants.
package mult_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;
endpackage

// File: rtl/mult_arbiter_if.sv
// Request/result bundle for mult_arbiter: two operand requesters, one result
// consumer, plus status (busy, ops_done).
interface mult_arbiter_if #(
  parameter int TAM   = 8,
  parameter int CNT_W = 16
);
  logic               req0_valid;
  logic               req0_ready;
  logic [TAM-1:0]     req0_a;
  logic [TAM-1:0]     req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [TAM-1:0]     req1_a;
  logic [TAM-1:0]     req1_b;
  logic               res_valid;
  logic               res_ready;
  logic [2*TAM-1:0]   res_s;
  logic               res_id;
  logic               busy;
  logic [CNT_W-1:0]   ops_done;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_s, res_id,
    output busy, ops_done
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_s, res_id,
    input  busy, ops_done
  );
endinterface

// File: rtl/mult_core.sv
// Registered unsigned multiplier: S is the full-width product of the
// operands presented on the previous rising edge.
module mult_core #(
  parameter int TAM = 8
) (
  input  logic               clk,
  input  logic [TAM-1:0]     A,
  input  logic [TAM-1:0]     B,
  output logic [2*TAM-1:0]   S
);
  logic [2*TAM-1:0] a_ext;
  logic [2*TAM-1:0] b_ext;

  assign a_ext = {{TAM{1'b0}}, A};
  assign b_ext = {{TAM{1'b0}}, B};

  always_ff @(posedge clk) begin
    S <= a_ext * b_ext;
  end
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of a shared multiplier: accepts one request
// at a time, multiplies in one cycle, holds the result until consumed.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int TAM   = 8,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  mult_arbiter_if.slave   bus
);
  state_t             state_reg;
  logic               last_grant_reg;
  logic [TAM-1:0]     op_a_reg;
  logic [TAM-1:0]     op_b_reg;
  logic               res_id_reg;
  logic               res_valid_reg;
  logic [CNT_W-1:0]   ops_done_reg;

  logic               gnt0;
  logic               gnt1;
  logic               hs;
  logic               hs_id;
  logic [TAM-1:0]     core_a;
  logic [TAM-1:0]     core_b;
  logic [2*TAM-1:0]   core_s;

  // Grant only in IDLE; on a tie the requester not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state_reg == IDLE) begin
      gnt0 = bus.req0_valid && (!bus.req1_valid || last_grant_reg == ID1);
      gnt1 = bus.req1_valid && (!bus.req0_valid || last_grant_reg == ID0);
    end
  end

  assign hs    = gnt0 | gnt1;
  assign hs_id = gnt1 ? ID1 : ID0;

  // Operands only change on a handshake, so the core output stays frozen
  // outside MUL; forcing zero during reset clears the result register too.
  assign core_a = rst ? '0 : op_a_reg;
  assign core_b = rst ? '0 : op_b_reg;

  mult_core #(.TAM(TAM)) u_core (
    .clk (clk),
    .A   (core_a),
    .B   (core_b),
    .S   (core_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= ID1;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      res_id_reg     <= ID0;
      res_valid_reg  <= 1'b0;
      ops_done_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hs) begin
            op_a_reg       <= gnt1 ? bus.req1_a : bus.req0_a;
            op_b_reg       <= gnt1 ? bus.req1_b : bus.req0_b;
            res_id_reg     <= hs_id;
            last_grant_reg <= hs_id;
            state_reg      <= MUL;
          end
        end
        MUL: begin
          res_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            ops_done_reg  <= ops_done_reg + 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.res_valid  = res_valid_reg;
  assign bus.res_s      = core_s;
  assign bus.res_id     = res_id_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.ops_done   = ops_done_reg;
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_mult_arbiter;
  localparam int TAM   = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;

  mult_arbiter_if #(.TAM(TAM), .CNT_W(CNT_W)) bus ();

  mult_arbiter #(.TAM(TAM), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: m_phase = cycles since the accepted request
  // (0 = nothing in flight, 1 = computing, 2 = result on offer).
  int          m_phase = 0;
  logic        m_last  = 1'b1;
  int          m_ops   = 0;
  logic [15:0] m_pend  = '0;
  logic [15:0] m_s     = '0;
  logic        m_id    = 1'b0;

  logic [15:0] obs_s;
  logic        obs_id;
  logic        obs_valid;
  int          obs_ops;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r,
                      input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                      input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                      input logic rr);
    logic e0, e1;
    rst            = r;
    bus.req0_valid = v0;
    bus.req0_a     = a0;
    bus.req0_b     = b0;
    bus.req1_valid = v1;
    bus.req1_a     = a1;
    bus.req1_b     = b1;
    bus.res_ready  = rr;
    @(negedge clk);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!r && m_phase == 0) begin
      if (v0 && (!v1 || m_last)) e0 = 1'b1;
      else if (v1)               e1 = 1'b1;
    end
    chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
    chk("res_valid",  32'(bus.res_valid),  32'(m_phase == 2));
    chk("busy",       32'(bus.busy),       32'(m_phase != 0));
    chk("res_s",      32'(bus.res_s),      32'(m_s));
    chk("res_id",     32'(bus.res_id),     32'(m_id));
    chk("ops_done",   32'(bus.ops_done),   32'(m_ops));
    obs_s     = bus.res_s;
    obs_id    = bus.res_id;
    obs_valid = bus.res_valid;
    obs_ops   = int'(bus.ops_done);
    @(posedge clk);
    if (r) begin
      m_phase = 0;
      m_last  = 1'b1;
      m_ops   = 0;
      m_s     = '0;
      m_id    = 1'b0;
    end else if (m_phase == 0) begin
      if (e0 || e1) begin
        m_pend  = e1 ? 16'(int'(a1) * int'(b1)) : 16'(int'(a0) * int'(b0));
        m_id    = e1;
        m_last  = e1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_s     = m_pend;
      m_phase = 2;
    end else if (rr) begin
      $display("retire id=%0d s=%0d ops=%0d", m_id, m_s, (m_ops + 1) % (1 << CNT_W));
      m_ops   = (m_ops + 1) % (1 << CNT_W);
      m_phase = 0;
    end
    #1;
  endtask

  task automatic idle_step(input logic rr);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, rr);
  endtask

  // One full request on req0 with an always-ready consumer; obs_* hold the
  // values seen in the result cycle.
  task automatic op0(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, a, b, 1'b0, 8'd0, 8'd0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.res_ready  = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);

    // Single request: 3*5
    op0(8'd3, 8'd5);
    chk("single_valid", 32'(obs_valid), 32'd1);
    chk("single_s", 32'(obs_s), 32'd15);
    chk("single_id", 32'(obs_id), 32'd0);
    idle_step(1'b1);
    chk("single_ops", 32'(obs_ops), 32'd1);

    // Round-robin ties, after a fresh reset
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i < 6) step(1'b0, 1'b1, 8'd2, 8'd7, 1'b1, 8'd4, 8'd4, 1'b1);
      else       step(1'b0, 1'b1, 8'd9, 8'd9, 1'b1, 8'd3, 8'd3, 1'b1);
      if (i == 2) begin chk("tie1_s", 32'(obs_s), 32'd14); chk("tie1_id", 32'(obs_id), 32'd0); end
      if (i == 5) begin chk("tie2_s", 32'(obs_s), 32'd16); chk("tie2_id", 32'(obs_id), 32'd1); end
      if (i == 8) begin chk("tie3_s", 32'(obs_s), 32'd81); chk("tie3_id", 32'(obs_id), 32'd0); end
    end

    // Backpressure: result held ten cycles with req1 waiting
    step(1'b0, 1'b1, 8'd10, 8'd11, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 8'd5, 1'b0);
    chk("bp_s_held", 32'(obs_s), 32'd110);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 8'd5, 1'b1);
    chk("bp_retire_valid", 32'(obs_valid), 32'd1);
    idle_step(1'b1);
    chk("bp_gone", 32'(obs_valid), 32'd0);

    // Boundary operands
    op0(8'd255, 8'd255);
    chk("max_s", 32'(obs_s), 32'hFE01);
    op0(8'd0, 8'd200);
    chk("zero_s", 32'(obs_s), 32'd0);

    // Reset while multiplying
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    step(1'b0, 1'b1, 8'd9, 8'd9, 1'b0, 8'd0, 8'd0, 1'b1);
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) idle_step(1'b1);
    chk("abort_valid", 32'(obs_valid), 32'd0);
    chk("abort_ops", 32'(obs_ops), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd6, 8'd7, 1'b1);
    chk("after_abort_s", 32'(obs_s), 32'd42);
    chk("after_abort_id", 32'(obs_id), 32'd1);

    // Counter wrap with a 4-bit counter
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      op0(8'(k), 8'd3);
      idle_step(1'b1);
      if (k == 15) chk("wrap15", 32'(obs_ops), 32'd15);
      if (k == 16) chk("wrap16", 32'(obs_ops), 32'd0);
      if (k == 17) chk("wrap17", 32'(obs_ops), 32'd1);
    end

    // Random traffic, occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(59) == 0),
           ($urandom_range(9) < 6), 8'($urandom), 8'($urandom),
           ($urandom_range(9) < 6), 8'($urandom), 8'($urandom),
           ($urandom_range(1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: TAM, default 8, operand width in bits; product width is 2*TAM.
REQ-002 Parameter: CNT_W, default 16, width of the completed-operation counter.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req0_valid  input  1  requester 0 has operands pending.
REQ-007 req0_ready  output  1  requester 0 operands accepted this cycle when req0_valid is also high.
REQ-008 req0_a, req0_b  input  TAM each  requester 0 operands, unsigned.
REQ-009 req1_valid  input  1  requester 1 has operands pending.
REQ-010 req1_ready  output  1  requester 1 operands accepted this cycle when req1_valid is also high.
REQ-011 req1_a, req1_b  input  TAM each  requester 1 operands, unsigned.
REQ-012 res_valid  output  1  result available.
REQ-013 res_ready  input  1  consumer takes the result.
REQ-014 res_s  output  2*TAM  unsigned product.
REQ-015 res_id  output  1  requester that owns res_s (0 or 1).
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 ops_done  output  CNT_W  count of results delivered.

Function
REQ-018 FSM states: IDLE, MUL, DONE.
- IDLE -> MUL on any handshake.
- MUL -> DONE unconditionally.
- DONE -> IDLE on res_ready.
REQ-019 Ready outputs in IDLE:
- req0_ready=1 only for requester 0 when it is granted; req1_ready=1 only for requester 1 when it is granted.
- Both ready outputs are 0 in MUL and DONE.
REQ-020 Grant, combinational in IDLE:
- Only one valid requester: that requester is granted.
- Both valid: the requester not in last_grant is granted (round-robin).
REQ-021 Handshake cycle (valid&ready):
- Capture the granted operands into op_a/op_b.
- Capture the requester id into res_id.
- Set last_grant to the id.
- The block samples operands only on this cycle; ungranted or unready inputs are ignored.
REQ-022 MUL: the mult_core computes op_a*op_b, full 2*TAM bits unsigned with no truncation, and registers it at the end of MUL.
REQ-023 Latency:
- Handshake in cycle N; res_valid=1 from cycle N+2.
- Minimum spacing between accepted requests is 3 cycles.
REQ-024 DONE:
- res_valid=1; res_s and res_id are held stable until the cycle res_ready=1.
- That cycle: res_valid drops next cycle, ops_done increments, FSM -> IDLE.
REQ-025 res_valid=0 in IDLE and MUL; res_s holds its last value outside DONE.
REQ-026 No request is accepted in the same cycle as result retirement; the next handshake occurs earliest in the IDLE cycle after.
REQ-027 ops_done wraps from 2^CNT_W-1 to 0 without flagging.
REQ-028 A requester that deasserts valid before its handshake loses nothing; the block holds no pending record.
REQ-029 busy=0 exactly when the state is IDLE.

Reset
REQ-030 On rst=1 at a clock edge:
- state=IDLE, res_valid=0, res_s=0, res_id=0, ops_done=0, busy=0.
- last_grant=1, so requester 0 wins the first tie.
REQ-031 Reset asserted in MUL or DONE aborts the operation; the in-flight result is discarded and never presented.
REQ-032 Ready outputs are 0 while rst=1.

Structure
REQ-033 A shared package mult_pkg holds:
- the state encoding: IDLE=2'd0, MUL=2'd1, DONE=2'd2;
- the requester id constants ID0=1'b0, ID1=1'b1.
REQ-034 A single sub-module mult_core (clk, A, B, S; registered unsigned multiply, TAM-parameterised) implements the datapath.
REQ-035 mult_arbiter owns arbitration, FSM, operand/id registers and the counter.

Verification
REQ-036 Single request: req0 a=3, b=5, held valid, res_ready=1 -> handshake cycle N, res_valid=1 at N+2 with res_s=15, res_id=0; ops_done=1 after retirement.
REQ-037 Tie after reset: both valid (req0 2*7, req1 4*4) -> req0 granted first (res_s=14, id 0), then req1 (res_s=16, id 1); a third tie with new operands grants req0.
REQ-038 Backpressure: res_ready=0 for 10 cycles in DONE -> res_valid, res_s and res_id stable; both ready outputs 0 throughout; retires on the first res_ready=1 cycle.
REQ-039 Boundary values: TAM=8, a=255, b=255 -> res_s=16'hFE01; a=0, b=200 -> res_s=0.
REQ-040 Reset mid-operation: rst pulsed in MUL -> next cycle IDLE, res_valid never asserted, ops_done=0; a subsequent req1 request is served normally.
REQ-041 Counter wrap: CNT_W=4, 17 completed ops -> ops_done reads 15 after the 15th op, 0 after the 16th, 1 after the 17th.
